mmio_io_ctrl: RTL and testbench

//  Memory-mapped I/O controller for the RISC-V core's IO region (addr[31:30]==2'b10).
//  It replaces the combinational UART/counter read mux with a registered read path
//  and an RX FIFO between the UART receiver and software.
//  It also provides a buffered TX holding register and NUM_CNT wrapping performance

---
 rtl/mmio_io_ctrl.sv | 139 +++++++++++++
 tb/tb_mmio_io_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: IO-region controller for the core. Registered load path,
// an RX byte FIFO from the UART receiver, a single TX holding register and
// a bank of wrapping performance counters that a store can clear.
module mmio_io_ctrl #(
  parameter int NUM_CNT  = 3,
  parameter int CNT_W    = 32,
  parameter int RX_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               io_sel,
  input  logic               io_re,
  input  logic               io_we,
  input  logic [31:0]        io_addr,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata,
  input  logic               uart_rx_valid,
  input  logic [7:0]         uart_rx_data,
  output logic               uart_rx_ready,
  output logic               uart_tx_valid,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_ready,
  input  logic [NUM_CNT-1:0] cnt_inc
);

  localparam int AW = $clog2(RX_DEPTH);

  localparam logic [8:0] OFF_STATUS = 9'h000;
  localparam logic [8:0] OFF_RXDATA = 9'h004;
  localparam logic [8:0] OFF_TXDATA = 9'h008;
  localparam logic [8:0] OFF_CLR    = 9'h018;
  localparam logic [8:0] OFF_CNT    = 9'h100;

  localparam logic [AW:0] RX_FULL_CNT = (AW+1)'(RX_DEPTH);

  // Registers
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [AW-1:0]    r_rx_wptr;
  logic [AW-1:0]    r_rx_rptr;
  logic [AW:0]      r_rx_cnt;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt [NUM_CNT];

  // Decode
  logic [8:0]  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_rx_full;
  logic        w_rx_nonempty;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_wr;
  logic        w_clr;
  logic [31:0] w_rd_data;
  logic        w_unused;

  // A store wins when both strobes are high, so a load needs io_we low.
  assign w_off         = io_addr[8:0];
  assign w_rd          = io_sel & io_re & ~io_we;
  assign w_wr          = io_sel & io_we;
  assign w_rx_full     = (r_rx_cnt == RX_FULL_CNT);
  assign w_rx_nonempty = (r_rx_cnt != '0);
  assign w_push        = uart_rx_valid & ~w_rx_full;
  assign w_pop         = w_rd & (w_off == OFF_RXDATA) & w_rx_nonempty;
  assign w_tx_wr       = w_wr & (w_off == OFF_TXDATA);
  assign w_clr         = w_wr & (w_off == OFF_CLR);
  assign w_unused      = ^{io_addr[31:9], io_wdata[31:8]};

  assign uart_rx_ready = ~w_rx_full;
  assign uart_tx_valid = r_tx_valid;
  assign uart_tx_data  = r_tx_data;
  assign io_rdata      = r_rdata;

  // Load data mux; unmapped or unaligned offsets read as zero
  always_comb begin
    w_rd_data = '0;
    if (w_off == OFF_STATUS) begin
      w_rd_data = {29'b0, w_rx_full, w_rx_nonempty, ~r_tx_valid};
    end else if (w_off == OFF_RXDATA) begin
      if (w_rx_nonempty) w_rd_data = {24'b0, r_rx_mem[r_rx_rptr]};
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_off == OFF_CNT + 9'(4 * i)) w_rd_data = 32'(r_cnt[i]);
      end
    end
  end

  // Registered load data; holds its value between loads
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_data;
  end

  // RX FIFO storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_rx_mem[r_rx_wptr] <= uart_rx_data;
  end

  // RX FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // TX holding register; a write while busy (including the accept cycle) is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (r_tx_valid) begin
      if (uart_tx_ready) r_tx_valid <= 1'b0;
    end else if (w_tx_wr) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= io_wdata[7:0];
    end
  end

  // Performance counters; clear beats a coincident increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst || w_clr)    r_cnt[i] <= '0;
      else if (cnt_inc[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed checks of the IO controller with CNT_W=4 so the
// counter wrap is reachable in a handful of cycles.
module tb_mmio_io_ctrl;

  localparam int NUM_CNT  = 3;
  localparam int CNT_W    = 4;
  localparam int RX_DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               io_sel;
  logic               io_re;
  logic               io_we;
  logic [31:0]        io_addr;
  logic [31:0]        io_wdata;
  logic [31:0]        io_rdata;
  logic               uart_rx_valid;
  logic [7:0]         uart_rx_data;
  logic               uart_rx_ready;
  logic               uart_tx_valid;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_ready;
  logic [NUM_CNT-1:0] cnt_inc;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  mmio_io_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .io_sel(io_sel), .io_re(io_re), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_ready(uart_rx_ready),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready),
    .cnt_inc(cnt_inc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    io_sel = 1'b0; io_re = 1'b0; io_we = 1'b0;
    io_addr = '0; io_wdata = '0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    io_sel = 1'b1; io_re = 1'b1; io_we = 1'b0; io_addr = a;
    tick();
    idle_bus();
    d = io_rdata;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_re = 1'b0; io_we = 1'b1; io_addr = a; io_wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic push(input logic [7:0] b);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    uart_rx_valid = 1'b0; uart_rx_data = '0;
    uart_tx_ready = 1'b0; cnt_inc = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_txv", 32'(uart_tx_valid), 32'h0);
    chk("rst_txd", 32'(uart_tx_data), 32'h0);
    chk("rst_rxrdy", 32'(uart_rx_ready), 32'h1);

    // 1: status after reset
    rd_reg(32'h8000_0000, rd); chk("t1_status", rd, 32'h1);

    // 2: two bytes in, two out, then empty
    push(8'h41); push(8'h42);
    rd_reg(32'h8000_0004, rd); chk("t2_rx0", rd, 32'h41);
    rd_reg(32'h8000_0004, rd); chk("t2_rx1", rd, 32'h42);
    rd_reg(32'h8000_0004, rd); chk("t2_rx_empty", rd, 32'h0);
    rd_reg(32'h8000_0000, rd); chk("t2_status", rd, 32'h1);

    // 3: fill (pointers start at 2, so they wrap), push+pop, drain
    for (int i = 0; i < RX_DEPTH; i++) push(8'h10 + 8'(i));
    chk("t3_rdy_full", 32'(uart_rx_ready), 32'h0);
    rd_reg(32'h8000_0000, rd); chk("t3_status_full", rd, 32'h7);
    rd_reg(32'h8000_0004, rd); chk("t3_pop0", rd, 32'h10);
    // simultaneous push and pop at count 7: count stays 7
    uart_rx_valid = 1'b1; uart_rx_data = 8'h18;
    rd_reg(32'h8000_0004, rd); chk("t3_pushpop", rd, 32'h11);
    uart_rx_valid = 1'b0;
    chk("t3_rdy_7", 32'(uart_rx_ready), 32'h1);
    push(8'h19);
    chk("t3_rdy_full2", 32'(uart_rx_ready), 32'h0);
    // a held byte while full is not accepted
    uart_rx_valid = 1'b1; uart_rx_data = 8'hEE;
    tick();
    uart_rx_valid = 1'b0;
    for (int i = 0; i < RX_DEPTH; i++) begin
      rd_reg(32'h8000_0004, rd); chk($sformatf("t3_drain%0d", i), rd, 32'h12 + 32'(i));
    end
    rd_reg(32'h8000_0000, rd); chk("t3_status_empty", rd, 32'h1);

    // 4: TX holding register
    wr_reg(32'h8000_0008, 32'hABCD_0055);
    chk("t4_txv", 32'(uart_tx_valid), 32'h1);
    chk("t4_txd", 32'(uart_tx_data), 32'h55);
    rd_reg(32'h8000_0000, rd); chk("t4_status_busy", rd, 32'h0);
    wr_reg(32'h8000_0008, 32'h66);
    chk("t4_drop", 32'(uart_tx_data), 32'h55);
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
    chk("t4_txv_clr", 32'(uart_tx_valid), 32'h0);
    wr_reg(32'h8000_0008, 32'h77);
    // accept and write in the same cycle: write dropped
    uart_tx_ready = 1'b1;
    wr_reg(32'h8000_0008, 32'h88);
    uart_tx_ready = 1'b0;
    chk("t4_acc_wr_v", 32'(uart_tx_valid), 32'h0);
    chk("t4_acc_wr_d", 32'(uart_tx_data), 32'h77);

    // 5: counters with wrap and clear
    wr_reg(32'h8000_0018, 32'h0);
    cnt_inc = 3'b001;
    for (int i = 0; i < 17; i++) tick();
    cnt_inc = 3'b000;
    rd_reg(32'h8000_0100, rd); chk("t5_cnt0_wrap", rd, 32'h1);
    rd_reg(32'h8000_0104, rd); chk("t5_cnt1", rd, 32'h0);
    cnt_inc = 3'b111;
    tick(); tick(); tick();
    cnt_inc = 3'b000;
    rd_reg(32'h8000_0100, rd); chk("t5_cnt0", rd, 32'h4);
    rd_reg(32'h8000_0108, rd); chk("t5_cnt2", rd, 32'h3);
    rd_reg(32'h8000_010C, rd); chk("t5_unmapped", rd, 32'h0);
    rd_reg(32'h8000_0102, rd); chk("t5_unaligned", rd, 32'h0);
    // io_sel low: no side effects
    io_sel = 1'b0; io_we = 1'b1; io_addr = 32'h8000_0018; tick(); idle_bus();
    rd_reg(32'h8000_0104, rd); chk("t5_nosel", rd, 32'h3);
    cnt_inc = 3'b111;
    wr_reg(32'h8000_0018, 32'hFFFF_FFFF);
    cnt_inc = 3'b000;
    rd_reg(32'h8000_0100, rd); chk("t5_clr0", rd, 32'h0);
    rd_reg(32'h8000_0104, rd); chk("t5_clr1", rd, 32'h0);
    rd_reg(32'h8000_0108, rd); chk("t5_clr2", rd, 32'h0);

    // 6: reset mid-operation
    push(8'hA1); push(8'hA2); push(8'hA3);
    wr_reg(32'h8000_0008, 32'hAA);
    cnt_inc = 3'b111; tick(); tick();
    rd_reg(32'h8000_0000, rd); chk("t6_pre_status", rd, 32'h2);
    rst = 1'b1; cnt_inc = 3'b000;
    io_sel = 1'b1; io_re = 1'b1; io_addr = 32'h8000_0100;
    tick();
    rst = 1'b0; idle_bus();
    chk("t6_rst_rdata", io_rdata, 32'h0);
    chk("t6_txv", 32'(uart_tx_valid), 32'h0);
    chk("t6_txd", 32'(uart_tx_data), 32'h0);
    chk("t6_rxrdy", 32'(uart_rx_ready), 32'h1);
    rd_reg(32'h8000_0000, rd); chk("t6_status", rd, 32'h1);
    rd_reg(32'h8000_0100, rd); chk("t6_cnt0", rd, 32'h0);
    rd_reg(32'h8000_0004, rd); chk("t6_rx_empty", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
